// File: rtl/char_mem_ctrl.sv
// char_mem_ctrl: glyph memory arbiter (read > fill > host write); bulk fill enabled by CHAR_MEM_CTRL_FILL_EN
module char_mem_ctrl #(
  parameter int COLS = 4,
  parameter int ROWS = 5
) (
  input  logic       clock,
  input  logic       rst_n,
  input  logic       rd_req,
  input  logic [1:0] rd_x,
  input  logic [2:0] rd_y,
  output logic       rd_valid,
  output logic       rd_data,
  input  logic       wr_valid,
  output logic       wr_ready,
  input  logic [1:0] wr_x,
  input  logic [2:0] wr_y,
  input  logic       wr_data,
  input  logic       fill_start,
  input  logic       fill_value,
  output logic       busy,
  output logic       fill_done,
  output logic       err,
  output logic       mem_write,
  output logic [1:0] mem_x,
  output logic [2:0] mem_y,
  output logic       mem_data_in,
  input  logic       mem_data_out
);
  logic rd_oob, wr_oob, wr_go, fill_go, fill_val;
  logic [1:0] fill_x;
  logic [2:0] fill_y;
  assign rd_oob = rd_y >= 3'(ROWS);
  assign wr_oob = wr_y >= 3'(ROWS);
  assign wr_go = wr_valid && wr_ready && !wr_oob;
`ifdef CHAR_MEM_CTRL_FILL_EN
  localparam int CELLS = COLS * ROWS;
  typedef enum logic {IDLE, FILL} state_t;
  state_t state, state_nx;
  logic [4:0] idx;
  logic fill_last;
  assign fill_go = state == FILL && !rd_req;
  assign fill_last = idx == 5'(CELLS - 1);
  assign fill_x = 2'(idx % 5'(COLS));
  assign fill_y = 3'(idx / 5'(COLS));
  assign wr_ready = !rd_req && state == IDLE;
  assign busy = state == FILL;
  always_comb begin
    state_nx = state;
    if (state == IDLE && fill_start) state_nx = FILL;
    else if (fill_go && fill_last) state_nx = IDLE;
  end
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      idx <= '0;
      fill_val <= 1'b0;
      fill_done <= 1'b0;
    end else begin
      state <= state_nx;
      fill_done <= fill_go && fill_last;
      if (state == IDLE && fill_start) begin
        idx <= '0;
        fill_val <= fill_value;
      end else if (fill_go) idx <= idx + 5'd1;
    end
`else
  logic [4:0] unused_cfg;
  assign unused_cfg = 5'(COLS) ^ {4'b0, fill_start ^ fill_value};
  assign fill_go = 1'b0;
  assign fill_val = 1'b0;
  assign fill_x = '0;
  assign fill_y = '0;
  assign wr_ready = !rd_req;
  assign busy = 1'b0;
  assign fill_done = 1'b0;
`endif
  assign mem_write = fill_go || wr_go;
  assign mem_x = rd_req ? rd_x : fill_go ? fill_x : wr_go ? wr_x : '0;
  assign mem_y = rd_req ? rd_y : fill_go ? fill_y : wr_go ? wr_y : '0;
  assign mem_data_in = fill_go ? fill_val : wr_go ? wr_data : 1'b0;
  always_ff @(posedge clock or negedge rst_n)
    if (!rst_n) begin
      rd_valid <= 1'b0;
      rd_data <= 1'b0;
      err <= 1'b0;
    end else begin
      rd_valid <= rd_req;
      if (rd_req) rd_data <= mem_data_out && !rd_oob;
      err <= err || (wr_valid && wr_ready && wr_oob);
    end
endmodule

// File: tb/tb_char_mem_ctrl.sv
// tb_char_mem_ctrl: directed bench with read scoreboard and a behavioural glyph memory
module tb_char_mem_ctrl;
  logic clock = 1'b0, rst_n = 1'b0;
  logic rd_req = 1'b0, wr_valid = 1'b0, wr_data = 1'b0, fill_start = 1'b0, fill_value = 1'b0;
  logic [1:0] rd_x = '0, wr_x = '0;
  logic [2:0] rd_y = '0, wr_y = '0;
  logic rd_valid, rd_data, wr_ready, busy, fill_done, err, mem_write, mem_data_in, mem_data_out;
  logic [1:0] mem_x;
  logic [2:0] mem_y;
  logic gmem [32] = '{default: 1'b0};
  logic refm [32] = '{default: 1'b0};
  logic exp_q [$];
  int checks = 0, failures = 0;
  int fidx, r;

  always #5 clock = ~clock;

  // location (1,7) is out of range and returns garbage 1 so masking is observable
  assign mem_data_out = (mem_y == 3'd7 && mem_x == 2'd1) ? 1'b1 : gmem[{mem_y, mem_x}];
  always @(posedge clock) if (mem_write) gmem[{mem_y, mem_x}] <= mem_data_in;

  char_mem_ctrl dut (
    .clock(clock), .rst_n(rst_n), .rd_req(rd_req), .rd_x(rd_x), .rd_y(rd_y),
    .rd_valid(rd_valid), .rd_data(rd_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_x(wr_x), .wr_y(wr_y), .wr_data(wr_data), .fill_start(fill_start),
    .fill_value(fill_value), .busy(busy), .fill_done(fill_done), .err(err),
    .mem_write(mem_write), .mem_x(mem_x), .mem_y(mem_y), .mem_data_in(mem_data_in),
    .mem_data_out(mem_data_out)
  );

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic rq, input logic [1:0] rx, input logic [2:0] ry,
                      input logic wv, input logic [1:0] wx, input logic [2:0] wy, input logic wd,
                      input logic fs, input logic fv);
    @(negedge clock);
    rd_req = rq; rd_x = rx; rd_y = ry;
    wr_valid = wv; wr_x = wx; wr_y = wy; wr_data = wd;
    fill_start = fs; fill_value = fv;
    if (rq) exp_q.push_back(ry < 3'd5 ? refm[{ry, rx}] : 1'b0);
    #1;
  endtask

  always @(negedge clock)
    if (rst_n && rd_valid) begin
      if (exp_q.size() == 0) chk("rd_unexpected", 8'(rd_valid), 8'd0);
      else chk("rd_data", 8'(rd_data), 8'(exp_q.pop_front()));
    end

  initial begin
    #2;
    chk("rst_rd_valid", 8'(rd_valid), 8'd0);
    chk("rst_rd_data", 8'(rd_data), 8'd0);
    chk("rst_busy", 8'(busy), 8'd0);
    chk("rst_fill_done", 8'(fill_done), 8'd0);
    chk("rst_err", 8'(err), 8'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("idle_mem_write", 8'(mem_write), 8'd0);
    chk("idle_mem_xy", 8'({mem_y, mem_x}), 8'd0);
    chk("idle_wr_ready", 8'(wr_ready), 8'd1);
    // single write then read back
    step(0, 0, 0, 1, 2'd2, 3'd3, 1, 0, 0);
    chk("wr_ready", 8'(wr_ready), 8'd1);
    chk("wr_mem_write", 8'(mem_write), 8'd1);
    chk("wr_mem_x", 8'(mem_x), 8'd2);
    chk("wr_mem_y", 8'(mem_y), 8'd3);
    chk("wr_mem_din", 8'(mem_data_in), 8'd1);
    refm[{3'd3, 2'd2}] = 1'b1;
    step(1, 2'd2, 3'd3, 0, 0, 0, 0, 0, 0);
    chk("rd_mem_write", 8'(mem_write), 8'd0);
    chk("rd_mem_xy", 8'({mem_y, mem_x}), 8'({3'd3, 2'd2}));
    chk("rd_wr_ready", 8'(wr_ready), 8'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_valid_lat1", 8'(rd_valid), 8'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("rd_valid_drop", 8'(rd_valid), 8'd0);
    // read and write in the same cycle: read wins, write waits
    step(1, 2'd0, 3'd0, 1, 2'd1, 3'd1, 1, 0, 0);
    chk("coll_wr_ready", 8'(wr_ready), 8'd0);
    chk("coll_mem_write", 8'(mem_write), 8'd0);
    step(0, 0, 0, 1, 2'd1, 3'd1, 1, 0, 0);
    chk("coll_wr_ready2", 8'(wr_ready), 8'd1);
    chk("coll_wr_xy", 8'({mem_write, mem_y, mem_x}), 8'({1'b1, 3'd1, 2'd1}));
    refm[{3'd1, 2'd1}] = 1'b1;
    step(0, 0, 0, 1, 2'd2, 3'd3, 0, 0, 0);
    refm[{3'd3, 2'd2}] = 1'b0;
    // back-to-back reads
    step(1, 2'd2, 3'd3, 0, 0, 0, 0, 0, 0);
    step(1, 2'd1, 3'd1, 0, 0, 0, 0, 0, 0);
    chk("b2b_valid1", 8'(rd_valid), 8'd1);
    step(1, 2'd0, 3'd0, 0, 0, 0, 0, 0, 0);
    chk("b2b_valid2", 8'(rd_valid), 8'd1);
    step(1, 2'd3, 3'd4, 0, 0, 0, 0, 0, 0);
    chk("b2b_valid3", 8'(rd_valid), 8'd1);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("b2b_valid4", 8'(rd_valid), 8'd1);
    // out-of-range write and read
    step(0, 0, 0, 1, 2'd1, 3'd5, 1, 0, 0);
    chk("oob_wr_ready", 8'(wr_ready), 8'd1);
    chk("oob_mem_write", 8'(mem_write), 8'd0);
    step(1, 2'd1, 3'd7, 0, 0, 0, 0, 0, 0);
    chk("oob_err", 8'(err), 8'd1);
    chk("oob_nowrite", 8'(gmem[{3'd5, 2'd1}]), 8'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("oob_rd_valid", 8'(rd_valid), 8'd1);
`ifdef CHAR_MEM_CTRL_FILL_EN
    // uninterrupted fill with value 1; fill_value toggles and fill_start repeats while busy
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 20; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 1, 1'(i));
      chk("fill_busy", 8'(busy), 8'd1);
      chk("fill_wr_ready", 8'(wr_ready), 8'd0);
      chk("fill_cell", 8'({mem_write, mem_data_in, mem_y, mem_x}), 8'({2'b11, 5'(i)}));
      chk("fill_done_early", 8'(fill_done), 8'd0);
      refm[i] = 1'b1;
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("fill_done", 8'(fill_done), 8'd1);
    chk("fill_busy_end", 8'(busy), 8'd0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("fill_done_pulse", 8'(fill_done), 8'd0);
    for (int i = 0; i < 20; i++) step(1, 2'(i % 4), 3'(i / 4), 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    // fill with value 0 interleaved with reads every other cycle
    step(0, 0, 0, 0, 0, 0, 0, 1, 0);
    fidx = 0;
    for (int c = 0; c < 40; c++) begin
      if (c % 2 == 0) begin
        r = (c * 7) % 20;
        step(1, 2'(r % 4), 3'(r / 4), 0, 0, 0, 0, 1, 1);
        chk("fill2_busy_rd", 8'(busy), 8'd1);
        chk("fill2_rd_nowrite", 8'(mem_write), 8'd0);
      end else begin
        step(0, 0, 0, 0, 0, 0, 0, 1, 1);
        chk("fill2_busy_wr", 8'(busy), 8'd1);
        chk("fill2_cell", 8'({mem_write, mem_data_in, mem_y, mem_x}), 8'({2'b10, 5'(fidx)}));
        refm[fidx] = 1'b0;
        fidx++;
      end
    end
    step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("fill2_done", 8'(fill_done), 8'd1);
    chk("fill2_busy_end", 8'(busy), 8'd0);
    // fill with value 1 abandoned by reset once idx reaches 10
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      refm[i] = 1'b1;
    end
    @(posedge clock);
    #2;
    chk("abort_busy_pre", 8'(busy), 8'd1);
`else
    step(0, 0, 0, 0, 0, 0, 0, 1, 1);
    step(0, 0, 0, 1, 2'd3, 3'd0, 1, 0, 0);
    chk("nofill_busy", 8'(busy), 8'd0);
    chk("nofill_done", 8'(fill_done), 8'd0);
    chk("nofill_wr_ready", 8'(wr_ready), 8'd1);
    chk("nofill_wr", 8'({mem_write, mem_y, mem_x}), 8'({1'b1, 3'd0, 2'd3}));
    refm[{3'd0, 2'd3}] = 1'b1;
    @(posedge clock);
    #2;
`endif
    chk("err_sticky", 8'(err), 8'd1);
    rst_n = 1'b0;
    #1;
    chk("arst_busy", 8'(busy), 8'd0);
    chk("arst_fill_done", 8'(fill_done), 8'd0);
    chk("arst_err", 8'(err), 8'd0);
    chk("arst_rd_valid", 8'(rd_valid), 8'd0);
    repeat (2) @(negedge clock);
    rst_n = 1'b1;
    step(1, 2'd1, 3'd2, 0, 0, 0, 0, 0, 0);
    chk("post_rst_done", 8'(fill_done), 8'd0);
    step(1, 2'd2, 3'd2, 0, 0, 0, 0, 0, 0);
    chk("post_rst_busy", 8'(busy), 8'd0);
    step(1, 2'd3, 3'd0, 0, 0, 0, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_done2", 8'(fill_done), 8'd0);
    chk("scoreboard_empty", 8'(exp_q.size()), 8'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
